// File: rtl/memory_access_pkg.sv
// Shared definitions for the memory-access stage: RV32 load/store funct3
// encodings, byte-enable constants, the stage FSM states and the
// misalignment test used when MEM_MISALIGN_TRAP_EN is defined.
package memory_access_pkg;

  // Load encodings (funct3)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store encodings (funct3); these share values with LB/LH/LW
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Byte-enable patterns
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // Halfword needs addr[0]==0, word needs addr[1:0]==0. Store codes
  // coincide with the load codes, so one case covers both directions.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic mis;
    mis = 1'b0;
    case (f3)
      F3_LH, F3_LHU: mis = lo[0];
      F3_LW:         mis = (lo != 2'b00);
      default:       mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/memory_access_load_extend.sv
// Load lane selection and sign/zero extension. Purely combinational.
// Halfword lanes use addr[1] only; unknown funct3 returns the full word.
module load_extend
  import memory_access_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lane, then extend according to the load type
  // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    result   = rdata;
    case (funct3)
      F3_LB:   result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  result = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   result = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  result = {{(XLEN-16){1'b0}}, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// Memory-access pipeline stage: passes ALU results through in one cycle,
// runs loads/stores against a ready-handshaked data memory while stalling
// upstream, and registers the MEM/WB result.
// Optional: MEM_MISALIGN_TRAP_EN makes misaligned half/word accesses
// complete immediately with misaligned=1 and no memory request.
module memory_access
  import memory_access_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] aluResult,
  input  logic [XLEN-1:0] aluOperand2,
  input  logic            memRead,
  input  logic            memWrite,
  input  logic            regWrite,
  input  logic [2:0]      funct3,
  input  logic [4:0]      rd,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_be,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            stall,
  output logic            wb_valid,
  output logic [XLEN-1:0] wb_result,
  output logic [4:0]      wb_rd,
  output logic            wb_regWrite,
  output logic [XLEN-1:0] aluResultMem,
  output logic            misaligned
);

  state_t          state_q, state_d;
  logic [XLEN-1:0] addr_q, wdata_q, load_data, store_data;
  logic [3:0]      be_q, store_be;
  logic [2:0]      funct3_q;
  logic [4:0]      rd_q;
  logic            we_q, read_q;
  logic            accept, is_mem, trap;

  assign accept = (state_q == IDLE) && ex_valid;
  assign is_mem = memRead || memWrite;

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap = is_mem && is_misaligned(funct3, aluResult[1:0]);
`else
  assign trap = 1'b0;
`endif

  // Store lane formatting: replicate the datum and enable the addressed bytes
  always_comb begin
    store_data = aluOperand2;
    store_be   = BE_WORD;
    case (funct3)
      F3_SB: begin
        store_data = {4{aluOperand2[7:0]}};
        store_be   = BE_BYTE0 << aluResult[1:0];
      end
      F3_SH: begin
        store_data = {2{aluOperand2[15:0]}};
        store_be   = aluResult[1] ? BE_HALF_HI : BE_HALF_LO;
      end
      default: begin
        store_data = aluOperand2;
        store_be   = BE_WORD;
      end
    endcase
  end

  // Next-state logic: enter ACCESS on an accepted aligned memory op, leave on ready
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && is_mem && !trap) state_d = ACCESS;
      ACCESS:  if (dmem_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign stall      = (state_q == ACCESS);
  assign dmem_req   = (state_q == ACCESS);
  assign dmem_addr  = {addr_q[XLEN-1:2], 2'b00};
  assign dmem_we    = we_q;
  assign dmem_wdata = wdata_q;
  assign dmem_be    = be_q;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .rdata   (dmem_rdata),
    .addr_lo (addr_q[1:0]),
    .funct3  (funct3_q),
    .result  (load_data)
  );

  // Request capture for the access in flight
  // NOTE: these datapath registers carry no reset; they are only observed while state_q==ACCESS, which reset clears.
  always_ff @(posedge clk) begin
    if (accept && is_mem) begin
      addr_q   <= aluResult;
      wdata_q  <= store_data;
      be_q     <= store_be;
      we_q     <= memWrite;
      read_q   <= memRead && !memWrite;
      funct3_q <= funct3;
      rd_q     <= rd;
    end
  end

  // State register and MEM/WB register
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      wb_valid     <= 1'b0;
      wb_result    <= '0;
      wb_rd        <= '0;
      wb_regWrite  <= 1'b0;
      aluResultMem <= '0;
    end else begin
      state_q  <= state_d;
      wb_valid <= 1'b0;
      if (accept) begin
        aluResultMem <= aluResult;
        if (!is_mem || trap) begin
          // ALU result, or a trapped misaligned access that writes nothing back
          wb_valid    <= 1'b1;
          wb_result   <= aluResult;
          wb_rd       <= rd;
          wb_regWrite <= regWrite && !trap;
        end
      end else if (state_q == ACCESS && dmem_ready) begin
        wb_valid    <= 1'b1;
        wb_result   <= read_q ? load_data : addr_q;
        wb_rd       <= rd_q;
        wb_regWrite <= read_q;
      end
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  // One-cycle misalignment flag alongside the trapped writeback
  always_ff @(posedge clk) begin
    if (!resetn) misaligned <= 1'b0;
    else         misaligned <= accept && trap;
  end
`else
  assign misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_memory_access.sv
// Self-checking bench for memory_access: a scoreboard queue holds the
// expected writebacks, per-scenario tasks check handshake and timing inline.
module tb_memory_access;
  import memory_access_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ex_valid;
  logic [31:0] aluResult, aluOperand2;
  logic        memRead, memWrite, regWrite;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        stall;
  logic        wb_valid;
  logic [31:0] wb_result;
  logic [4:0]  wb_rd;
  logic        wb_regWrite;
  logic [31:0] aluResultMem;
  logic        misaligned;

  memory_access #(.XLEN(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .ex_valid     (ex_valid),
    .aluResult    (aluResult),
    .aluOperand2  (aluOperand2),
    .memRead      (memRead),
    .memWrite     (memWrite),
    .regWrite     (regWrite),
    .funct3       (funct3),
    .rd           (rd),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_be      (dmem_be),
    .dmem_ready   (dmem_ready),
    .dmem_rdata   (dmem_rdata),
    .stall        (stall),
    .wb_valid     (wb_valid),
    .wb_result    (wb_result),
    .wb_rd        (wb_rd),
    .wb_regWrite  (wb_regWrite),
    .aluResultMem (aluResultMem),
    .misaligned   (misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        rw;
    logic        chk;
  } wb_exp_t;

  wb_exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int req_seen = 0;

  // Scoreboard: every writeback must match the oldest expectation
  always @(negedge clk) begin : monitor
    wb_exp_t e;
    if (dmem_req === 1'b1) req_seen++;
    if (resetn === 1'b1 && wb_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got writeback result=%h rd=%0d, expected none", wb_result, wb_rd);
      end else begin
        e = exp_q.pop_front();
        if (wb_rd !== e.rd || wb_regWrite !== e.rw || (e.chk && wb_result !== e.result)) begin
          errors++;
          $display("FAIL wb_data: got result=%h rd=%0d rw=%b, expected result=%h rd=%0d rw=%b",
                   wb_result, wb_rd, wb_regWrite, e.result, e.rd, e.rw);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

  task automatic push(input logic [31:0] res, input logic [4:0] r, input logic rw, input logic chk);
    wb_exp_t e;
    e.result = res; e.rd = r; e.rw = rw; e.chk = chk;
    exp_q.push_back(e);
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; memRead = 1'b0; memWrite = 1'b0; regWrite = 1'b0;
  endtask

  // One-cycle EX request; returns at the negedge after the accepting edge
  task automatic issue(input logic rd_i, input logic wr_i, input logic rw_i, input logic [2:0] f3,
                       input logic [4:0] rd_n, input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    ex_valid = 1'b1; memRead = rd_i; memWrite = wr_i; regWrite = rw_i;
    funct3 = f3; rd = rd_n; aluResult = addr; aluOperand2 = data;
    @(negedge clk);
    idle_inputs();
  endtask

  // Memory responder: keeps ready low for latency-1 cycles, then completes
  task automatic respond(input logic [31:0] rdata, input int latency, input logic [31:0] exp_addr);
    checks++;
    if (dmem_addr !== exp_addr) begin
      errors++;
      $display("FAIL dmem_addr: got %h, expected %h", dmem_addr, exp_addr);
    end
    for (int i = 0; i < latency; i++) begin
      checks++;
      if (stall !== 1'b1 || dmem_req !== 1'b1) begin
        errors++;
        $display("FAIL access_hold: cycle %0d got stall=%b req=%b, expected 1/1", i, stall, dmem_req);
      end
      if (i == latency - 1) begin
        dmem_ready = 1'b1;
        dmem_rdata = rdata;
      end
      @(negedge clk);
    end
    dmem_ready = 1'b0;
    checks++;
    if (stall !== 1'b0 || wb_valid !== 1'b1 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL access_done: got stall=%b wb_valid=%b req=%b, expected 0/1/0", stall, wb_valid, dmem_req);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle_inputs();
    funct3 = 3'b000; rd = 5'd0; aluResult = 32'h0; aluOperand2 = 32'h0;
    dmem_ready = 1'b0; dmem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    checks++;
    if (wb_valid !== 1'b0 || wb_regWrite !== 1'b0 || wb_rd !== 5'd0 || wb_result !== 32'h0) begin
      errors++;
      $display("FAIL reset_wb: got valid=%b rw=%b rd=%0d res=%h, expected all 0", wb_valid, wb_regWrite, wb_rd, wb_result);
    end
    checks++;
    if (aluResultMem !== 32'h0 || misaligned !== 1'b0 || stall !== 1'b0 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_misc: got fwd=%h mis=%b stall=%b req=%b, expected all 0", aluResultMem, misaligned, stall, dmem_req);
    end
    resetn = 1'b1;
  endtask

  task automatic test_alu();
    int r0;
    r0 = req_seen;
    push(32'h55, 5'd3, 1'b1, 1'b1);
    issue(1'b0, 1'b0, 1'b1, 3'b000, 5'd3, 32'h55, 32'h0);
    checks++;
    if (wb_valid !== 1'b1 || wb_result !== 32'h55 || aluResultMem !== 32'h55 || stall !== 1'b0) begin
      errors++;
      $display("FAIL alu_latency: got valid=%b res=%h fwd=%h stall=%b, expected 1/55/55/0", wb_valid, wb_result, aluResultMem, stall);
    end
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL no_valid_idle: got wb_valid=%b, expected 0", wb_valid);
    end
    checks++;
    if (req_seen != r0) begin
      errors++;
      $display("FAIL alu_no_req: got %0d request cycles, expected 0", req_seen - r0);
    end
  endtask

  task automatic test_lw();
    push(32'hDEADBEEF, 5'd5, 1'b1, 1'b1);
    issue(1'b1, 1'b0, 1'b1, F3_LW, 5'd5, 32'h100, 32'h0);
    checks++;
    if (dmem_we !== 1'b0 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL lw_start: got we=%b wb_valid=%b, expected 0/0", dmem_we, wb_valid);
    end
    respond(32'hDEADBEEF, 3, 32'h100);
  endtask

  task automatic test_load_extend();
    logic [2:0]  f3s [6] = '{F3_LB, F3_LBU, F3_LH, F3_LHU, F3_LB, 3'b011};
    logic [31:0] ads [6] = '{32'h103, 32'h103, 32'h102, 32'h0, 32'h101, 32'h104};
    logic [31:0] rds [6] = '{32'h80000000, 32'h80000000, 32'h80010000, 32'h0000F00D, 32'h00007F00, 32'h12345678};
    logic [31:0] exs [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h0000F00D, 32'h0000007F, 32'h12345678};
    for (int i = 0; i < 6; i++) begin
      push(exs[i], 5'(i + 10), 1'b1, 1'b1);
      issue(1'b1, 1'b0, 1'b1, f3s[i], 5'(i + 10), ads[i], 32'h0);
      respond(rds[i], 1, {ads[i][31:2], 2'b00});
    end
  endtask

  task automatic test_store();
    logic [2:0]  f3s [3] = '{F3_SH, F3_SB, F3_SW};
    logic [31:0] ads [3] = '{32'h102, 32'h101, 32'h200};
    logic [31:0] dts [3] = '{32'h00001234, 32'h000000AB, 32'hCAFEF00D};
    logic [3:0]  bes [3] = '{4'b1100, 4'b0010, 4'b1111};
    logic [31:0] wds [3] = '{32'h12341234, 32'hABABABAB, 32'hCAFEF00D};
    for (int i = 0; i < 3; i++) begin
      push(32'h0, 5'd20, 1'b0, 1'b0);
      issue(1'b0, 1'b1, 1'b0, f3s[i], 5'd20, ads[i], dts[i]);
      checks++;
      if (dmem_be !== bes[i] || dmem_wdata !== wds[i] || dmem_we !== 1'b1) begin
        errors++;
        $display("FAIL store_fmt %0d: got be=%b wdata=%h we=%b, expected be=%b wdata=%h we=1",
                 i, dmem_be, dmem_wdata, dmem_we, bes[i], wds[i]);
      end
      respond(32'h0, 2, {ads[i][31:2], 2'b00});
    end
  endtask

  // EX held valid across a stall: the new op must wait until the stage is idle
  task automatic test_held_input();
    push(32'h11112222, 5'd7, 1'b1, 1'b1);
    push(32'h77, 5'd8, 1'b1, 1'b1);
    @(negedge clk);
    ex_valid = 1'b1; memRead = 1'b1; memWrite = 1'b0; regWrite = 1'b1;
    funct3 = F3_LW; rd = 5'd7; aluResult = 32'h300;
    @(negedge clk);
    memRead = 1'b0; rd = 5'd8; aluResult = 32'h77;
    @(negedge clk);
    checks++;
    if (stall !== 1'b1 || aluResultMem !== 32'h300) begin
      errors++;
      $display("FAIL held_stall: got stall=%b fwd=%h, expected 1/300", stall, aluResultMem);
    end
    dmem_ready = 1'b1; dmem_rdata = 32'h11112222;
    @(negedge clk);
    dmem_ready = 1'b0;
    @(negedge clk);
    idle_inputs();
    checks++;
    if (wb_valid !== 1'b1 || wb_result !== 32'h77 || aluResultMem !== 32'h77) begin
      errors++;
      $display("FAIL held_accept: got valid=%b res=%h fwd=%h, expected 1/77/77", wb_valid, wb_result, aluResultMem);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      ex_valid = 1'b1; memRead = 1'b0; memWrite = 1'b0; regWrite = (i % 2 == 0);
      aluResult = $urandom; rd = 5'(i + 1);
      push(aluResult, rd, regWrite, 1'b1);
      @(negedge clk);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_reset_access();
    issue(1'b1, 1'b0, 1'b1, F3_LW, 5'd4, 32'h400, 32'h0);
    checks++;
    if (dmem_req !== 1'b1) begin
      errors++;
      $display("FAIL rst_acc_start: got req=%b, expected 1", dmem_req);
    end
    resetn = 1'b0;
    @(negedge clk);
    checks++;
    if (dmem_req !== 1'b0 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_acc_abandon: got req=%b wb_valid=%b, expected 0/0", dmem_req, wb_valid);
    end
    resetn = 1'b1;
    dmem_ready = 1'b1; dmem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    dmem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (dmem_req !== 1'b0 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_acc_after: got req=%b wb_valid=%b, expected 0/0", dmem_req, wb_valid);
    end
  endtask

  task automatic test_misalign();
`ifdef MEM_MISALIGN_TRAP_EN
    int r0;
    r0 = req_seen;
    push(32'h0, 5'd9, 1'b0, 1'b0);
    issue(1'b1, 1'b0, 1'b1, F3_LW, 5'd9, 32'h101, 32'h0);
    checks++;
    if (misaligned !== 1'b1 || wb_valid !== 1'b1 || wb_regWrite !== 1'b0 || dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL mis_trap: got mis=%b valid=%b rw=%b req=%b, expected 1/1/0/0", misaligned, wb_valid, wb_regWrite, dmem_req);
    end
    @(negedge clk);
    checks++;
    if (misaligned !== 1'b0 || req_seen != r0) begin
      errors++;
      $display("FAIL mis_after: got mis=%b req_cycles=%0d, expected 0/0", misaligned, req_seen - r0);
    end
`else
    push(32'hA5A5A5A5, 5'd9, 1'b1, 1'b1);
    issue(1'b1, 1'b0, 1'b1, F3_LW, 5'd9, 32'h101, 32'h0);
    checks++;
    if (misaligned !== 1'b0) begin
      errors++;
      $display("FAIL mis_tied: got mis=%b, expected 0", misaligned);
    end
    respond(32'hA5A5A5A5, 1, 32'h100);
    push(32'h0, 5'd9, 1'b0, 1'b0);
    issue(1'b0, 1'b1, 1'b0, F3_SH, 5'd9, 32'h103, 32'h00005678);
    checks++;
    if (dmem_be !== 4'b1100 || dmem_wdata !== 32'h56785678) begin
      errors++;
      $display("FAIL mis_sh_ignore: got be=%b wdata=%h, expected 1100/56785678", dmem_be, dmem_wdata);
    end
    respond(32'h0, 1, 32'h100);
`endif
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lw();
    test_load_extend();
    test_store();
    test_held_input();
    test_back_to_back();
    test_reset_access();
    test_misalign();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d outstanding writebacks, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
